// File: rtl/lsu_pkg.sv
// Shared LSU definitions: RISC-V funct3 width codes, FSM encoding and lane helpers.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } lsu_state_e;

   function automatic logic f3_unsupported(input logic [2:0] f3);
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

   // Half enables ignore addr[0], word enables ignore addr[1:0]: accesses are forced aligned.
   function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      if (f3[1:0] == F3_SB[1:0])
         be = 4'b0001 << off;
      else if (f3[1:0] == F3_SH[1:0])
         be = 4'b0011 << {off[1], 1'b0};
      else
         be = 4'b1111;
      return be;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction and sign/zero extension of a memory read word (purely combinational).
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (off)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = off[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   data = {{16{half_sel[15]}}, half_sel};
         F3_LW:   data = rdata;
         F3_LBU:  data = {24'b0, byte_sel};
         F3_LHU:  data = {16'b0, half_sel};
         default: data = 32'b0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time, best case store done 2 / load done 3 cycles after accept;
// req_ready only in IDLE, mem_req held until mem_gnt. MISALIGN_EXC_EN traps misaligned half/word.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        Load_Done,
   output logic        Store_Done,
   output logic [31:0] Load_Data,
   output logic        misalign
);

   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q, off_d;
   logic        skip_q, skip_d;
   logic        mis_q, mis_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [29:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        load_done_q, load_done_d;
   logic        store_done_q, store_done_d;
   logic [31:0] load_data_q, load_data_d;
   logic        misalign_q, misalign_d;

   logic        req_unsup;
   logic        req_mis;
   logic        req_skip;
   logic [31:0] req_wdata_rep;
   logic [31:0] ld_aligned;

   assign req_unsup = f3_unsupported(req_funct3);

`ifdef MISALIGN_EXC_EN
   assign req_mis = !req_unsup &&
                    (((req_funct3[1:0] == F3_SH[1:0]) && req_addr[0]) ||
                     ((req_funct3[1:0] == F3_SW[1:0]) && (req_addr[1:0] != 2'b00)));
`else
   assign req_mis = 1'b0;
`endif

   assign req_skip = req_unsup || req_mis;

   always_comb begin
      if (req_funct3[1:0] == F3_SB[1:0])
         req_wdata_rep = {4{req_wdata[7:0]}};
      else if (req_funct3[1:0] == F3_SH[1:0])
         req_wdata_rep = {2{req_wdata[15:0]}};
      else
         req_wdata_rep = req_wdata;
   end

   lsu_load_align u_load_align (
      .funct3 (funct3_q),
      .off    (off_q),
      .rdata  (mem_rdata),
      .data   (ld_aligned)
   );

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      skip_d       = skip_q;
      mis_d        = mis_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_be_d     = mem_be_q;
      mem_wdata_d  = mem_wdata_q;
      load_done_d  = 1'b0;
      store_done_d = 1'b0;
      load_data_d  = load_data_q;
      misalign_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d     = REQ;
               we_d        = req_we;
               funct3_d    = req_funct3;
               off_d       = req_addr[1:0];
               skip_d      = req_skip;
               mis_d       = req_mis;
               mem_req_d   = !req_skip;
               mem_we_d    = req_we && !req_skip;
               mem_addr_d  = req_addr[31:2];
               mem_be_d    = req_skip ? 4'b0000 : lane_be(req_funct3, req_addr[1:0]);
               mem_wdata_d = req_wdata_rep;
            end
         end
         REQ: begin
            // Skipped accesses complete without ever touching memory.
            if (skip_q) begin
               state_d      = RESP;
               load_done_d  = !we_q;
               store_done_d = we_q;
               misalign_d   = mis_q;
               if (!we_q)
                  load_data_d = 32'b0;
            end else if (mem_gnt) begin
               mem_req_d = 1'b0;
               if (we_q) begin
                  state_d      = RESP;
                  store_done_d = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               state_d     = RESP;
               load_done_d = 1'b1;
               load_data_d = ld_aligned;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         funct3_q     <= 3'b0;
         off_q        <= 2'b0;
         skip_q       <= 1'b0;
         mis_q        <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 30'b0;
         mem_be_q     <= 4'b0;
         mem_wdata_q  <= 32'b0;
         load_done_q  <= 1'b0;
         store_done_q <= 1'b0;
         load_data_q  <= 32'b0;
         misalign_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         skip_q       <= skip_d;
         mis_q        <= mis_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         load_done_q  <= load_done_d;
         store_done_q <= store_done_d;
         load_data_q  <= load_data_d;
         misalign_q   <= misalign_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_be     = mem_be_q;
   assign mem_wdata  = mem_wdata_q;
   assign Load_Done  = load_done_q;
   assign Store_Done = store_done_q;
   assign Load_Data  = load_data_q;
   assign misalign   = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table with a completion scoreboard plus reset corner cases.
module tb_load_store_unit;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        mem_req;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        Load_Done;
   logic        Store_Done;
   logic [31:0] Load_Data;
   logic        misalign;

   load_store_unit dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .Load_Done  (Load_Done),
      .Store_Done (Store_Done),
      .Load_Data  (Load_Data),
      .misalign   (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          dly;
      logic        skip;
      logic        mis;
      logic [3:0]  be;
      logic [31:0] mwdata;
      logic [31:0] ld;
   } vec_t;

   typedef struct {
      bit          is_load;
      bit          mis;
      int          cyc;
      logic [31:0] ld;
   } exp_t;

   vec_t        vt[$];
   exp_t        sb[$];
   int          n_pass  = 0;
   int          n_total = 0;
   logic [31:0] last_ld = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
   endtask

   task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input int dly,
                      input logic skip, input logic mis, input logic [3:0] be,
                      input logic [31:0] mwdata, input logic [31:0] ld);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.dly = dly;
      v.skip = skip; v.mis = mis; v.be = be; v.mwdata = mwdata; v.ld = ld;
      vt.push_back(v);
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      bit   done_seen;
      bit   gnt_prev;
      int   nreq;
      chk("ready_idle", req_ready, 1'b1);
      req_valid  = 1'b1;
      req_we     = v.we;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      mem_rdata  = v.rdata;
      e.is_load  = !v.we;
      e.mis      = v.mis;
      e.ld       = v.we ? last_ld : v.ld;
      e.cyc      = v.skip ? 2 : ((v.we ? 2 : 3) + v.dly);
      sb.push_back(e);
      @(posedge clk); #1;
      // Junk on the request bus after acceptance must not leak into mem_* outputs.
      req_valid  = 1'b0;
      req_we     = 1'($urandom_range(1));
      req_funct3 = 3'($urandom_range(7));
      req_addr   = $urandom();
      req_wdata  = $urandom();
      done_seen  = 1'b0;
      gnt_prev   = 1'b0;
      nreq       = 0;
      for (int c = 1; c <= 40 && !done_seen; c++) begin
         mem_gnt    = 1'b0;
         mem_rvalid = 1'b0;
         if (Load_Done || Store_Done) begin
            done_seen = 1'b1;
            chk("sb_depth", sb.size(), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("done_cycle", c, e.cyc);
               chk("load_done", Load_Done, e.is_load);
               chk("store_done", Store_Done, !e.is_load);
               chk("load_data", Load_Data, e.ld);
               chk("misalign", misalign, e.mis);
               last_ld = e.ld;
            end
         end else begin
            if (mem_req) begin
               chk("mem_addr", mem_addr, v.addr[31:2]);
               chk("mem_be", mem_be, v.be);
               chk("mem_we", mem_we, v.we);
               if (v.we)
                  chk("mem_wdata", mem_wdata, v.mwdata);
               nreq++;
               if (nreq > v.dly)
                  mem_gnt = 1'b1;
            end
            if (gnt_prev && !v.we)
               mem_rvalid = 1'b1;
            gnt_prev = mem_gnt;
            @(posedge clk); #1;
         end
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      sb.delete();
      chk("done_seen", done_seen, 1'b1);
      chk("mem_req_cycles", nreq, v.skip ? 0 : v.dly + 1);
      @(posedge clk); #1;
      chk("pulse_low", {Load_Done, Store_Done, misalign}, 3'b000);
      chk("data_hold", Load_Data, last_ld);
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;

      //   we    f3      addr      wdata         rdata         dly skip mis be       mwdata        ld
      add(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1'b0, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0);
      add(1'b0, 3'b000, 32'h13, 32'h0,        32'h80000000, 0, 1'b0, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80);
      add(1'b0, 3'b100, 32'h13, 32'h0,        32'h80000000, 0, 1'b0, 1'b0, 4'b1000, 32'h0, 32'h00000080);
      add(1'b0, 3'b001, 32'h22, 32'h0,        32'h80011234, 3, 1'b0, 1'b0, 4'b1100, 32'h0, 32'hFFFF8001);
      add(1'b0, 3'b101, 32'h22, 32'h0,        32'h80011234, 0, 1'b0, 1'b0, 4'b1100, 32'h0, 32'h00008001);
      add(1'b0, 3'b001, 32'h20, 32'h0,        32'h80011234, 0, 1'b0, 1'b0, 4'b0011, 32'h0, 32'h00001234);
      add(1'b0, 3'b000, 32'h01, 32'h0,        32'h0000F500, 0, 1'b0, 1'b0, 4'b0010, 32'h0, 32'hFFFFFFF5);
      add(1'b0, 3'b010, 32'h40, 32'h0,        32'h12345678, 1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h12345678);
      add(1'b0, 3'b011, 32'h30, 32'h0,        32'hFFFFFFFF, 0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0);
      add(1'b1, 3'b110, 32'h46, 32'h5555AAAA, 32'h0,        0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0);
      add(1'b1, 3'b000, 32'h05, 32'h000000A7, 32'h0,        0, 1'b0, 1'b0, 4'b0010, 32'hA7A7A7A7, 32'h0);
      add(1'b1, 3'b001, 32'h0E, 32'hFFFFBEEF, 32'h0,        2, 1'b0, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0);
`ifdef MISALIGN_EXC_EN
      add(1'b0, 3'b010, 32'h06, 32'h0,        32'hCAFEF00D, 0, 1'b1, 1'b1, 4'b0000, 32'h0, 32'h0);
      add(1'b1, 3'b001, 32'h03, 32'h00001122, 32'h0,        0, 1'b1, 1'b1, 4'b0000, 32'h0, 32'h0);
`else
      add(1'b0, 3'b010, 32'h06, 32'h0,        32'hCAFEF00D, 0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'hCAFEF00D);
      add(1'b1, 3'b001, 32'h03, 32'h00001122, 32'h0,        0, 1'b0, 1'b0, 4'b1100, 32'h11221122, 32'h0);
`endif

      // Reset values after release.
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      chk("rst_ready", req_ready, 1'b1);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_be", mem_be, 4'b0000);
      chk("rst_pulses", {Load_Done, Store_Done, misalign}, 3'b000);
      chk("rst_load_data", Load_Data, 32'h0);

      // Stray grant/read-valid while idle must do nothing.
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h89ABCDEF;
      @(posedge clk); #1;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      chk("stray_ready", req_ready, 1'b1);
      chk("stray_pulses", {Load_Done, Store_Done, mem_req}, 3'b000);
      chk("stray_data", Load_Data, 32'h0);

      foreach (vt[i])
         run_vec(vt[i]);

      // Reset while waiting for read data; the late read-valid must be dropped.
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h40;
      mem_rdata  = 32'h00000055;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("wr_mem_req", mem_req, 1'b1);
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      chk("wr_in_wait", {req_ready, mem_req}, 2'b00);
      reset = 1'b1;
      #1;
      chk("wr_async_ready", req_ready, 1'b1);
      chk("wr_async_data", Load_Data, 32'h0);
      @(posedge clk); #1;
      reset      = 1'b0;
      mem_rvalid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         mem_rvalid = 1'b0;
         chk("wr_no_done", {Load_Done, Store_Done}, 2'b00);
      end
      chk("wr_load_data", Load_Data, 32'h0);
      chk("wr_ready", req_ready, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
